// File: rtl/shield_pkg.sv
// shield_pkg: shared FSM state codes, AXI burst encoding and beat-size helper for the shield write path.
package shield_pkg;
  localparam logic [0:0] SHIELD_ST_IDLE = 1'b0;
  localparam logic [0:0] SHIELD_ST_SPLIT = 1'b1;
  localparam logic [1:0] SHIELD_BURST_INCR = 2'b01;
  function automatic logic [2:0] shield_beat_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/shield_counter.sv
// shield_counter: loadable down-counter; load wins over subtract in the same cycle.
module shield_counter #(
  parameter int C_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [C_WIDTH-1:0] ld_val,
  input  logic               sub,
  input  logic [C_WIDTH-1:0] sub_val,
  output logic [C_WIDTH-1:0] cnt
);
  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = ld ? ld_val : sub ? cnt_q - sub_val : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/shield_write_line_splitter.sv
// shield_write_line_splitter: splits an AXI INCR write burst into per-cache-line requests.
// Define SHIELD_WR_SPLIT_CHECK_EN to flag non-INCR or wrong-size bursts on err_unsupported.
module shield_write_line_splitter
  import shield_pkg::*;
#(
  parameter int CL_ID_WIDTH = 6,
  parameter int ADDR_WIDTH = 64,
  parameter int CL_DATA_WIDTH = 64,
  parameter int OFFSET_WIDTH = 6,
  parameter int BURSTS_PER_LINE = 8,
  parameter int BURSTS_PER_LINE_LOG = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CL_ID_WIDTH-1:0]  s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  output logic [ADDR_WIDTH-1:0]   line_addr,
  output logic [7:0]              burst_count,
  output logic [OFFSET_WIDTH-1:0] burst_start_offset,
  output logic [CL_ID_WIDTH-1:0]  line_id,
  output logic                    line_first,
  output logic                    line_last,
  output logic                    req_val,
  input  logic                    req_rdy,
  output logic                    busy,
  output logic                    err_unsupported
);
  localparam int BEAT_LOG = OFFSET_WIDTH - BURSTS_PER_LINE_LOG;
  logic [0:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [CL_ID_WIDTH-1:0] id_q, id_d;
  logic first_q, first_d;
  logic awready_en_q;
  logic [8:0] beats_rem, room, cnt9;
  logic [BURSTS_PER_LINE_LOG-1:0] start_idx;
  logic aw_hs, fire, last;
  assign s_axi_awready = awready_en_q && state_q == SHIELD_ST_IDLE;
  assign req_val = state_q == SHIELD_ST_SPLIT;
  assign busy = state_q != SHIELD_ST_IDLE;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign fire = req_val && req_rdy;
  assign start_idx = cur_addr_q[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG];
  assign room = 9'(BURSTS_PER_LINE) - 9'(start_idx);
  assign last = beats_rem <= room;
  assign cnt9 = last ? beats_rem : room;
  assign burst_count = cnt9[7:0];
  assign line_addr = {cur_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign burst_start_offset = {start_idx, {BEAT_LOG{1'b0}}};
  assign line_id = id_q;
  assign line_first = first_q;
  assign line_last = req_val && last;
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    id_d = id_q;
    first_d = first_q;
    if (aw_hs) begin
      state_d = SHIELD_ST_SPLIT;
      cur_addr_d = s_axi_awaddr;
      id_d = s_axi_awid;
      first_d = 1'b1;
    end else if (fire) begin
      state_d = last ? SHIELD_ST_IDLE : SHIELD_ST_SPLIT;
      cur_addr_d = line_addr + (ADDR_WIDTH'(1) << OFFSET_WIDTH);
      first_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SHIELD_ST_IDLE;
      cur_addr_q <= '0;
      id_q <= '0;
      first_q <= 1'b0;
      awready_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      id_q <= id_d;
      first_q <= first_d;
      awready_en_q <= 1'b1;
    end
  shield_counter #(.C_WIDTH(9)) u_beats_rem (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (aw_hs),
    .ld_val ({1'b0, s_axi_awlen} + 9'd1),
    .sub    (fire),
    .sub_val(cnt9),
    .cnt    (beats_rem)
  );
`ifdef SHIELD_WR_SPLIT_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = aw_hs && (s_axi_awburst != SHIELD_BURST_INCR ||
                                s_axi_awsize != shield_beat_size(CL_DATA_WIDTH));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_unsupported = err_q;
  logic unused_ok;
  assign unused_ok = ^cur_addr_q[BEAT_LOG-1:0];
`else
  assign err_unsupported = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{cur_addr_q[BEAT_LOG-1:0], s_axi_awburst, s_axi_awsize};
`endif
endmodule

// File: tb/tb_shield_write_line_splitter.sv
// tb_shield_write_line_splitter: directed and random bursts against a line-split reference model.
module tb_shield_write_line_splitter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] s_axi_awid = '0;
  logic [63:0] s_axi_awaddr = '0;
  logic [7:0] s_axi_awlen = '0;
  logic [2:0] s_axi_awsize = 3'd3;
  logic [1:0] s_axi_awburst = 2'b01;
  logic s_axi_awvalid = 1'b0, s_axi_awready;
  logic [63:0] line_addr;
  logic [7:0] burst_count;
  logic [5:0] burst_start_offset, line_id;
  logic line_first, line_last, req_val, busy, err_unsupported;
  logic req_rdy = 1'b0;
  int total = 0, bad = 0;
  typedef struct {
    logic [63:0] la;
    logic [7:0] cnt;
    logic [5:0] off;
    logic f, l;
  } req_t;
  always #5 clk = ~clk;
  shield_write_line_splitter dut (
    .clk(clk), .rst_n(rst_n), .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .line_addr(line_addr),
    .burst_count(burst_count), .burst_start_offset(burst_start_offset), .line_id(line_id),
    .line_first(line_first), .line_last(line_last), .req_val(req_val), .req_rdy(req_rdy),
    .busy(busy), .err_unsupported(err_unsupported)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  // mode: 0 always ready, 1 ready toggles 1/0, 2 random ready
  task automatic burst(input logic [63:0] a, input logic [7:0] len, input logic [5:0] id,
                       input logic [1:0] bt, input logic [2:0] sz, input int mode);
    req_t q[$];
    req_t r;
    logic [63:0] cur = a;
    int beats = int'(len) + 1;
    int k = 0, cyc = 0, to = 0, room;
    logic rdy, want_err;
    while (beats > 0) begin
      room = 8 - int'(cur[5:3]);
      r.la = cur & ~64'h3F;
      r.cnt = 8'(beats < room ? beats : room);
      r.off = {cur[5:3], 3'b000};
      r.f = q.size() == 0;
      r.l = beats <= room;
      q.push_back(r);
      beats -= room;
      cur = r.la + 64'h40;
    end
`ifdef SHIELD_WR_SPLIT_CHECK_EN
    want_err = bt != 2'b01 || sz != 3'd3;
`else
    want_err = 1'b0;
`endif
    @(negedge clk);
    while (!s_axi_awready && to < 20) begin
      @(negedge clk);
      to++;
    end
    check("aw_ready", 64'(s_axi_awready), 64'd1);
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awid = id;
    s_axi_awburst = bt; s_axi_awsize = sz; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check("err_pulse", 64'(err_unsupported), 64'(want_err));
    check("aw_ready_split", 64'(s_axi_awready), 64'd0);
    while (k < q.size() && cyc < 2000) begin
      if (cyc == 1) check("err_once", 64'(err_unsupported), 64'd0);
      check("req_val", 64'(req_val), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("line_addr", line_addr, q[k].la);
      check("burst_count", 64'(burst_count), 64'(q[k].cnt));
      check("start_offset", 64'(burst_start_offset), 64'(q[k].off));
      check("line_id", 64'(line_id), 64'(id));
      check("line_first", 64'(line_first), 64'(q[k].f));
      check("line_last", 64'(line_last), 64'(q[k].l));
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      req_rdy = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    if (k < q.size()) check("req_timeout", 64'(k), 64'(q.size()));
    req_rdy = 1'b0;
    check("idle_req_val", 64'(req_val), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_aw_ready", 64'(s_axi_awready), 64'd1);
  endtask
  initial begin
    #3;
    check("rst_req_val", 64'(req_val), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_aw_ready", 64'(s_axi_awready), 64'd0);
    check("rst_err", 64'(err_unsupported), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("aw_ready_after_rst", 64'(s_axi_awready), 64'd1);
    burst(64'h1000, 8'd7, 6'd3, 2'b01, 3'd3, 0);
    burst(64'h1028, 8'd9, 6'd5, 2'b01, 3'd3, 0);
    burst(64'h0, 8'd255, 6'd9, 2'b01, 3'd3, 1);
    burst(64'hFFFF_FFFF_FFFF_FFC0, 8'd15, 6'd1, 2'b01, 3'd3, 0);
    burst(64'h2000, 8'd3, 6'd2, 2'b10, 3'd3, 0);
    burst(64'h3010, 8'd4, 6'd4, 2'b01, 3'd2, 2);
    // reset mid-burst: 4-line burst, two lines accepted, then reset
    @(negedge clk);
    s_axi_awaddr = 64'h4000; s_axi_awlen = 8'd31; s_axi_awid = 6'd7;
    s_axi_awburst = 2'b01; s_axi_awsize = 3'd3; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    req_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_val", 64'(req_val), 64'd1);
    check("mid_line_addr", line_addr, 64'h4080);
    req_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_val", 64'(req_val), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_aw_ready", 64'(s_axi_awready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_aw_ready", 64'(s_axi_awready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_req", 64'(req_val), 64'd0);
      @(negedge clk);
    end
    req_rdy = 1'b0;
    for (int i = 0; i < 25; i++)
      burst({$urandom, $urandom}, $urandom_range(0, 3) == 0 ? 8'd255 : 8'($urandom_range(0, 20)),
            6'($urandom), $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b01,
            $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'd3, int'($urandom_range(0, 2)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
